// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: n/co/ci loop walker and address issuer for the vector x matrix
// engine. Issues one {input, weight, bias, accumulate} address tuple per cycle,
// tags each issue and delays the tag PIPE_LAT stages to drive datapath controls
// and the output write address. stall freezes issue, drain and the tag pipeline.
// Optional build macro: MM_SEQ_PERF_CNT_EN adds busy/stall cycle counters.
module mm_seq_ctrl #(
  parameter int unsigned IN_AW    = 11,
  parameter int unsigned W_AW     = 13,
  parameter int unsigned B_AW     = 9,
  parameter int unsigned C_W      = 8,
  parameter int unsigned N_W      = 16,
  parameter int unsigned PIPE_LAT = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [IN_AW-1:0] in_base,
  input  logic [W_AW-1:0]  w_base,
  input  logic [B_AW-1:0]  b_base,
  input  logic [IN_AW-1:0] out_base,
  input  logic [C_W-1:0]   ci_num,
  input  logic [C_W-1:0]   co_num,
  input  logic [N_W-1:0]   n_num,
  input  logic             en_bias,
  input  logic             en_acc,
  input  logic             en_relu,
  input  logic             stall,
  output logic [IN_AW-1:0] in_addr,
  output logic             in_addr_valid,
  output logic [W_AW-1:0]  w_addr,
  output logic             w_addr_valid,
  output logic [B_AW-1:0]  b_addr,
  output logic             b_addr_valid,
  output logic [IN_AW-1:0] acc_addr,
  output logic             acc_addr_valid,
  output logic             dp_clr,
  output logic             dp_last,
  output logic             dp_relu,
  output logic [IN_AW-1:0] out_addr,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef MM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_busy_cyc,
  output logic [31:0]      perf_stall_cyc
`endif
);

  localparam int unsigned DW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic             v;
    logic             first;
    logic             last;
    logic [IN_AW-1:0] addr;
  } tag_t;

  state_t state_q, state_d;

  logic [C_W-1:0]   ci_num_q, co_num_q, ci_q, co_q;
  logic [N_W-1:0]   n_num_q, n_q;
  logic [W_AW-1:0]  w_base_q, w_row;
  logic [B_AW-1:0]  b_base_q, b_cur;
  logic [IN_AW-1:0] in_row, acc_cur;
  logic             en_bias_q, en_acc_q, en_relu_q, zero_q;
  logic [DW-1:0]    drain_q;

  logic [IN_AW-1:0] in_addr_q, acc_addr_q;
  logic [W_AW-1:0]  w_addr_q;
  logic [B_AW-1:0]  b_addr_q;
  logic             in_v_q, b_v_q, acc_v_q;
  logic             done_q, err_q;

  tag_t tag_q [0:PIPE_LAT];

  logic launch, issue_go, last_ci, last_co, last_n, zero_dim;

  assign launch   = (state_q == S_IDLE) && start;
  assign issue_go = (state_q == S_RUN) && !stall;
  assign last_ci  = (ci_q == C_W'(ci_num_q - 1'b1));
  assign last_co  = (co_q == C_W'(co_num_q - 1'b1));
  assign last_n   = (n_q == N_W'(n_num_q - 1'b1));
  assign zero_dim = (ci_num == '0) || (co_num == '0) || (n_num == '0);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = zero_dim ? S_DONE : S_RUN;
      S_RUN:   if (issue_go && last_ci && last_co && last_n) state_d = S_DRAIN;
      S_DRAIN: if (!stall && drain_q == DW'(PIPE_LAT - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Config latch, loop counters and running address bases
  // (n*Ci, co*Ci and n*Co+co are kept as running sums; acc_cur steps by one
  // per completed ci loop because n*Co+co is linear in the co/n carry chain)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ci_num_q <= '0; co_num_q <= '0; n_num_q <= '0;
      ci_q <= '0; co_q <= '0; n_q <= '0;
      w_base_q <= '0; b_base_q <= '0;
      in_row <= '0; w_row <= '0; b_cur <= '0; acc_cur <= '0;
      en_bias_q <= 1'b0; en_acc_q <= 1'b0; en_relu_q <= 1'b0; zero_q <= 1'b0;
    end else if (launch) begin
      ci_num_q <= ci_num; co_num_q <= co_num; n_num_q <= n_num;
      ci_q <= '0; co_q <= '0; n_q <= '0;
      w_base_q <= w_base; b_base_q <= b_base;
      in_row <= in_base; w_row <= w_base; b_cur <= b_base; acc_cur <= out_base;
      en_bias_q <= en_bias; en_acc_q <= en_acc; en_relu_q <= en_relu;
      zero_q <= zero_dim;
    end else if (issue_go) begin
      if (last_ci) begin
        ci_q    <= '0;
        acc_cur <= acc_cur + 1'b1;
        if (last_co) begin
          co_q   <= '0;
          w_row  <= w_base_q;
          b_cur  <= b_base_q;
          n_q    <= last_n ? '0 : n_q + 1'b1;
          in_row <= in_row + IN_AW'(ci_num_q);
        end else begin
          co_q  <= co_q + 1'b1;
          w_row <= w_row + W_AW'(ci_num_q);
          b_cur <= b_cur + 1'b1;
        end
      end else begin
        ci_q <= ci_q + 1'b1;
      end
    end
  end

  // Drain counter: PIPE_LAT non-stalled cycles after the last issue
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            drain_q <= '0;
    else if (state_q == S_RUN)            drain_q <= '0;
    else if (state_q == S_DRAIN && !stall) drain_q <= drain_q + 1'b1;
  end

  // Issue registers; held while stalled so the pending tuple is re-presented
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_addr_q <= '0; w_addr_q <= '0; b_addr_q <= '0; acc_addr_q <= '0;
      in_v_q <= 1'b0; b_v_q <= 1'b0; acc_v_q <= 1'b0;
    end else if (!stall) begin
      in_v_q  <= issue_go;
      b_v_q   <= issue_go && last_ci && en_bias_q;
      acc_v_q <= issue_go && last_ci && en_acc_q;
      if (issue_go) begin
        in_addr_q  <= in_row + IN_AW'(ci_q);
        w_addr_q   <= w_row + W_AW'(ci_q);
        b_addr_q   <= b_cur;
        acc_addr_q <= acc_cur;
      end
    end
  end

  // Tag pipeline: stage 0 aligns with the issue registers, stage PIPE_LAT drives the datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i <= PIPE_LAT; i++) tag_q[i] <= '0;
    end else if (!stall) begin
      tag_q[0] <= '{v: issue_go, first: issue_go && (ci_q == '0),
                    last: issue_go && last_ci, addr: acc_cur};
      for (int unsigned i = 1; i <= PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Completion status, registered one cycle after the DONE state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      err_q  <= (state_q == S_DONE) && zero_q;
    end
  end

  assign in_addr        = in_addr_q;
  assign w_addr         = w_addr_q;
  assign b_addr         = b_addr_q;
  assign acc_addr       = acc_addr_q;
  assign in_addr_valid  = in_v_q && !stall;
  assign w_addr_valid   = in_v_q && !stall;
  assign b_addr_valid   = b_v_q && !stall;
  assign acc_addr_valid = acc_v_q && !stall;
  assign dp_clr         = tag_q[PIPE_LAT].v && tag_q[PIPE_LAT].first && !stall;
  assign dp_last        = tag_q[PIPE_LAT].v && tag_q[PIPE_LAT].last && !stall;
  assign dp_relu        = dp_last && en_relu_q;
  assign out_valid      = dp_last;
  assign out_addr       = tag_q[PIPE_LAT].addr;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign err            = err_q;

`ifdef MM_SEQ_PERF_CNT_EN
  // Saturating busy / stall cycle counters, cleared on launch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (launch) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (state_q != S_IDLE && perf_busy_cyc != '1)
        perf_busy_cyc <= perf_busy_cyc + 1'b1;
      if ((state_q == S_RUN || state_q == S_DRAIN) && stall && perf_stall_cyc != '1)
        perf_stall_cyc <= perf_stall_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Testbench for mm_seq_ctrl: directed and randomized launches checked against a
// loop-level reference model (nested n/co/ci loops with plain multiplication).
module tb_mm_seq_ctrl;
  localparam int IN_AW = 11, W_AW = 13, B_AW = 9, C_W = 8, N_W = 16, PL = 10;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, stall = 1'b0;
  logic en_bias = 1'b0, en_acc = 1'b0, en_relu = 1'b0;
  logic [IN_AW-1:0] in_base = '0, out_base = '0;
  logic [W_AW-1:0]  w_base = '0;
  logic [B_AW-1:0]  b_base = '0;
  logic [C_W-1:0]   ci_num = '0, co_num = '0;
  logic [N_W-1:0]   n_num = '0;
  logic [IN_AW-1:0] in_addr, acc_addr, out_addr;
  logic [W_AW-1:0]  w_addr;
  logic [B_AW-1:0]  b_addr;
  logic in_addr_valid, w_addr_valid, b_addr_valid, acc_addr_valid;
  logic dp_clr, dp_last, dp_relu, out_valid, busy, done, err;

  mm_seq_ctrl #(.IN_AW(IN_AW), .W_AW(W_AW), .B_AW(B_AW), .C_W(C_W), .N_W(N_W),
                .PIPE_LAT(PL)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .in_base(in_base), .w_base(w_base), .b_base(b_base), .out_base(out_base),
    .ci_num(ci_num), .co_num(co_num), .n_num(n_num),
    .en_bias(en_bias), .en_acc(en_acc), .en_relu(en_relu), .stall(stall),
    .in_addr(in_addr), .in_addr_valid(in_addr_valid),
    .w_addr(w_addr), .w_addr_valid(w_addr_valid),
    .b_addr(b_addr), .b_addr_valid(b_addr_valid),
    .acc_addr(acc_addr), .acc_addr_valid(acc_addr_valid),
    .dp_clr(dp_clr), .dp_last(dp_last), .dp_relu(dp_relu),
    .out_addr(out_addr), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IN_AW-1:0] in_a;
    logic [W_AW-1:0]  w_a;
    logic [B_AW-1:0]  b_a;
    logic             bv;
    logic [IN_AW-1:0] acc_a;
    logic             accv;
    logic             ev;
  } iss_t;

  typedef struct packed {
    logic             clr;
    logic             last;
    logic             relu;
    logic [IN_AW-1:0] oa;
  } dpe_t;

  iss_t exp_iss[$];
  dpe_t exp_dp[$];
  int   lat_q[$];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, {in_addr, w_addr, b_addr, acc_addr}, 64'd0);
    chk({tag, "_ctl"}, {out_addr, in_addr_valid, w_addr_valid, b_addr_valid, acc_addr_valid,
                        dp_clr, dp_last, dp_relu, out_valid, busy, done, err}, 64'd0);
  endtask

  // smode: 0 no stall, 1 five-cycle bursts mid-RUN and mid-DRAIN, 2 random stalls
  task automatic run_case(input int nn, input int nco, input int nci,
                          input logic [IN_AW-1:0] ib, input logic [W_AW-1:0] wb,
                          input logic [B_AW-1:0] bb, input logic [IN_AW-1:0] ob,
                          input logic eb, input logic ea, input logic er,
                          input int smode, input int abort_at);
    iss_t e;
    dpe_t d;
    int nissue, work, p, nst, s1, s2, c, dstate, spur_c, limit, li;
    bit fin;
    exp_iss.delete(); exp_dp.delete(); lat_q.delete();
    nissue = nn * nco * nci;
    for (int n = 0; n < nn; n++)
      for (int co = 0; co < nco; co++)
        for (int ci = 0; ci < nci; ci++) begin
          e.in_a  = IN_AW'(int'(ib) + n * nci + ci);
          e.w_a   = W_AW'(int'(wb) + co * nci + ci);
          e.b_a   = B_AW'(int'(bb) + co);
          e.bv    = eb && (ci == nci - 1);
          e.acc_a = IN_AW'(int'(ob) + n * nco + co);
          e.accv  = ea && (ci == nci - 1);
          e.ev    = (ci == 0) || (ci == nci - 1);
          exp_iss.push_back(e);
          if (e.ev) begin
            d.clr  = (ci == 0);
            d.last = (ci == nci - 1);
            d.relu = d.last && er;
            d.oa   = e.acc_a;
            exp_dp.push_back(d);
          end
        end
    work   = (nissue == 0) ? 0 : nissue + PL;
    dstate = (work == 0) ? 1 : 1000000;
    spur_c = (work == 0) ? 1 : 5;
    limit  = work + 80;

    @(posedge clk); #1;
    start = 1'b1; stall = 1'b0;
    in_base = ib; w_base = wb; b_base = bb; out_base = ob;
    ci_num = C_W'(nci); co_num = C_W'(nco); n_num = N_W'(nn);
    en_bias = eb; en_acc = ea; en_relu = er;
    p = 0; nst = 0; s1 = 0; s2 = 0; c = 0; fin = 0;

    while (!fin && c < limit) begin
      c++;
      @(posedge clk); #1;
      // Config inputs churn after launch; a second start arrives while busy
      start    = (c == spur_c);
      in_base  = IN_AW'($urandom); w_base = W_AW'($urandom);
      b_base   = B_AW'($urandom);  out_base = IN_AW'($urandom);
      ci_num   = C_W'($urandom_range(0, 5)); co_num = C_W'($urandom_range(0, 5));
      n_num    = N_W'($urandom_range(0, 5));
      en_bias  = 1'($urandom); en_acc = 1'($urandom); en_relu = 1'($urandom);
      stall = 1'b0;
      if (p < work) begin
        if (smode == 1) begin
          if (p == 4 && s1 < 5) begin stall = 1'b1; s1++; end
          else if (p == nissue + 3 && s2 < 5) begin stall = 1'b1; s2++; end
        end else if (smode == 2) begin
          stall = (nst < 30) && ($urandom_range(0, 2) == 0);
        end
      end
      if (stall) nst++;
      else if (p < work) begin
        p++;
        if (p == work) dstate = c + 1;
      end

      @(negedge clk);
      if (stall)
        chk("stall_mask", {in_addr_valid, w_addr_valid, b_addr_valid, acc_addr_valid,
                           dp_clr, dp_last, dp_relu, out_valid}, 64'd0);
      if (in_addr_valid) begin
        if (exp_iss.size() == 0) chk("extra_issue", 64'd1, 64'd0);
        else begin
          e = exp_iss.pop_front();
          chk("in_addr", 64'(in_addr), 64'(e.in_a));
          chk("w_addr", 64'(w_addr), 64'(e.w_a));
          chk("w_valid", 64'(w_addr_valid), 64'd1);
          chk("b_valid", 64'(b_addr_valid), 64'(e.bv));
          if (e.bv) chk("b_addr", 64'(b_addr), 64'(e.b_a));
          chk("acc_valid", 64'(acc_addr_valid), 64'(e.accv));
          if (e.accv) chk("acc_addr", 64'(acc_addr), 64'(e.acc_a));
          if (e.ev) lat_q.push_back(c);
        end
      end else begin
        chk("orphan_valid", {w_addr_valid, b_addr_valid, acc_addr_valid}, 64'd0);
      end
      if (dp_clr || dp_last || dp_relu || out_valid) begin
        if (exp_dp.size() == 0) chk("extra_dp", 64'd1, 64'd0);
        else begin
          d = exp_dp.pop_front();
          chk("dp_flags", {dp_clr, dp_last, dp_relu, out_valid},
                          {d.clr, d.last, d.relu, d.last});
          if (d.last) chk("out_addr", 64'(out_addr), 64'(d.oa));
          if (lat_q.size() != 0) begin
            li = lat_q.pop_front();
            if (smode == 0) chk("latency", 64'(c - li), 64'(PL));
          end
        end
      end
      chk("busy", 64'(busy), 64'(c <= dstate));
      chk("done", 64'(done), 64'(c == dstate + 1));
      chk("err", 64'(err), 64'((c == dstate + 1) && (nissue == 0)));
      if (c == dstate + 1) fin = 1;

      if (c == abort_at) begin
        #2 rstn = 1'b0;
        #1 chk_all_zero("abort_reset");
        @(posedge clk); #1;
        rstn = 1'b1; stall = 1'b0; start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    if (!fin) chk("done_timeout", 64'd0, 64'd1);
    chk("leftover", 64'(exp_iss.size() + exp_dp.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nn, nco, nci;
    rstn = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    run_case(2, 2, 3, 'h10, 'h100, 'h4, 'h20, 0, 0, 0, 0, 0);
    run_case(2, 2, 3, 'h10, 'h100, 'h4, 'h20, 1, 1, 0, 0, 0);
    run_case(3, 1, 1, 'h30, 'h40, 'h1, 'h50, 0, 0, 1, 0, 0);
    run_case(2, 2, 3, 'h10, 'h100, 'h4, 'h20, 1, 1, 1, 1, 0);
    run_case(2, 2, 0, 'h10, 'h100, 'h4, 'h20, 1, 1, 1, 0, 0);
    run_case(2, 0, 2, 'h10, 'h100, 'h4, 'h20, 1, 1, 1, 0, 0);
    run_case(0, 2, 2, 'h10, 'h100, 'h4, 'h20, 1, 1, 1, 0, 0);
    run_case(2, 2, 3, 'h10, 'h100, 'h4, 'h20, 1, 1, 1, 0, 8);
    run_case(2, 2, 3, 'h10, 'h100, 'h4, 'h20, 1, 1, 1, 0, 0);
    run_case(3, 3, 3, 'h7FE, 'h1FFE, 'h1FF, 'h7FF, 1, 1, 1, 2, 0);

    for (int k = 0; k < 16; k++) begin
      nn  = $urandom_range(1, 4);
      nco = $urandom_range(1, 4);
      nci = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) nci = 0;
      run_case(nn, nco, nci, IN_AW'($urandom), W_AW'($urandom), B_AW'($urandom),
               IN_AW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
